fixed_seq_arith: RTL
====================

// Module: fixed_seq_arith
// PURPOSE
//  Sequential, parametrised unsigned fixed-point add/multiply unit; successor to the
//  combinational 8.8 fixed adder/multiplier. Operand format is INT_W.FRAC_W with a
//  valid/ready handshake on both sides. Multiply is iterative shift-add (1 multiplier
//  bit/cycle). Optional saturation on overflow. Sits between operand regs and result bus.
// PARAMETERS
//  INT_W   8  integer bits per operand/result
//  FRAC_W  8  fraction bits per operand/result; W = INT_W+FRAC_W (W >= 2)
//  SAT     0  1: overflowing result clamps to all-ones; 0: result wraps/truncates
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  in_valid   in   1  operands/op valid
//  in_ready   out  1  unit can accept operands (high only in IDLE)
//  op         in   1  0 = add, 1 = multiply; sampled on accept
//  num1       in   W  operand A (multiplicand)
//  num2       in   W  operand B (multiplier)
//  out_valid  out  1  result/overflow valid (high only in DONE)
//  out_ready  in   1  consumer takes result
//  result     out  W  INT_W.FRAC_W result
//  overflow   out  1  integer part exceeded INT_W bits
//  busy       out  1  high in MUL or DONE
// BEHAVIOUR
//  Reset: the interface is one clock domain; rst_n is asynchronous, active-low. On
//   reset: state=IDLE, result=0, overflow=0, out_valid=0, busy=0, in_ready=1.
//   Internal accumulator and bit counter are cleared.
//  Reset mid-operation aborts the operation; no output is produced.
//  FSM: IDLE -> (accept & op=0) -> DONE; IDLE -> (accept & op=1) -> MUL;
//   MUL -> (counter reaches W-1) -> DONE; DONE -> (out_valid & out_ready) -> IDLE.
//  Accept = in_valid & in_ready at a rising edge. Operands and op are latched on accept.
//  Changes to num1/num2/op after accept have no effect.
//  Add: {ovf,sum} = A+B, computed W+1 bits wide. Result and overflow are registered at
//   the accept edge, so out_valid is high from that edge (latency 1).
//  Multiply: 2W-bit product P = A*B, exact. At each MUL edge, examine multiplier bit i
//   (LSB first) and add A<<i to the accumulator when the bit is 1. That is W iteration
//   edges after accept; out_valid rises at the W-th edge after accept (W=16 -> 16).
//   result = P[FRAC_W+W-1:FRAC_W]; low FRAC_W bits are truncated toward zero.
//   overflow = |P[2W-1:FRAC_W+W].
//  SAT=1: if overflow, result = {W{1'b1}}; overflow flag still 1. SAT=0: the raw
//   truncated bits are output.
//  DONE: result/overflow are held stable while out_ready=0, indefinitely.
//  in_ready=0 in MUL and DONE; in_valid is ignored there, with no queueing.
//  Back-to-back: after the output handshake edge, in_ready is 1 in the next cycle. There
//   is no same-cycle accept in DONE.
//  result/overflow keep their last value in IDLE. Only out_valid qualifies them.
//  Operands of 0 are not special-cased; multiply always takes W cycles.
// TESTING
//  1 W=16 SAT=0, mul 0x0180*0x0200 (1.5*2.0) -> result 0x0300, ovf 0,
//    out_valid exactly 16 edges after accept
//  2 mul 0x8000*0x0200 -> P=0x01000000: SAT=0 result 0x0000 ovf 1;
//    SAT=1 result 0xFFFF ovf 1. mul 0x0001*0x0001 -> 0x0000 ovf 0 (truncation)
//  3 add 0xFF00+0x0200 -> SAT=0 result 0x0100 ovf 1, SAT=1 0xFFFF ovf 1;
//    add 0x0180+0x0080 -> 0x0200 ovf 0, out_valid 1 edge after accept
//  4 Backpressure: hold out_ready=0 for 5 cycles in DONE with in_valid=1 and new
//    operands -> result stable, in_ready=0, no accept. Release -> IDLE, next op accepted
//  5 Reset: assert rst_n=0 asynchronously at iteration 7 of a multiply -> all outputs
//    go to reset values immediately. Next multiply 0x0300*0x0300 -> 0x0900 ovf 0
//  6 Random regression for INT_W/FRAC_W in {(8,8),(4,12),(12,4)} and SAT in {0,1} vs a
//    reference model using the exact product/sum rules above

Source files
------------

// File: rtl/fixed_seq_arith.sv
// Sequential unsigned INT_W.FRAC_W fixed-point add / shift-add multiply unit
// with valid/ready handshakes on operand and result sides.
module fixed_seq_arith #(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8,
  parameter bit SAT    = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op,
  input  logic [INT_W+FRAC_W-1:0] num1,
  input  logic [INT_W+FRAC_W-1:0] num2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INT_W+FRAC_W-1:0] result,
  output logic                    overflow,
  output logic                    busy
);

  localparam int W  = INT_W + FRAC_W;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // MUL   | one multiplier bit per edge, LSB first
  // DONE  | result held until out_ready
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [2*W-1:0]   acc;
  logic [CW-1:0]    cnt;

  logic [2*W-1:0]   partial;
  logic [2*W-1:0]   acc_next;
  logic [W:0]       sum;
  logic [W-1:0]     add_res;
  logic [W-1:0]     mul_res;
  logic             add_ovf;
  logic             mul_ovf;

  always_comb begin
    partial  = b_q[cnt] ? ({{W{1'b0}}, a_q} << cnt) : '0;
    acc_next = acc + partial;
    // add result comes straight from the ports so it lands on the accept edge
    sum      = {1'b0, num1} + {1'b0, num2};
    add_ovf  = sum[W];
    add_res  = (SAT && add_ovf) ? '1 : sum[W-1:0];
    mul_ovf  = |acc_next[2*W-1:FRAC_W+W];
    mul_res  = (SAT && mul_ovf) ? '1 : acc_next[FRAC_W+W-1:FRAC_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      cnt       <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= num1;
            b_q      <= num2;
            acc      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (op) begin
              state <= MUL;
            end else begin
              result    <= add_res;
              overflow  <= add_ovf;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        MUL: begin
          acc <= acc_next;
          if (cnt == LAST) begin
            result    <= mul_res;
            overflow  <= mul_ovf;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
